// File: rtl/pwm_pkg.sv
// Shared types for the PWM carrier generator and its shadow register.
package pwm_pkg;

    localparam int unsigned PWM_CW = 16;

    typedef enum logic {PWM_OFF, PWM_ON} _pwm_onoff;

    typedef enum logic {CARRIER_SAW, CARRIER_TRI} carrier_mode_t;

    typedef enum logic {DirUp, DirDown} dir_t;

endpackage

// File: rtl/pwm_shadow_reg.sv
// Shadow period/compare/mode registers with a valid/ready write port; the shadow moves into
// the active registers only when the counter signals a commit opportunity.
module pwm_shadow_reg
    import pwm_pkg::*;
#(
    parameter int unsigned   CW         = PWM_CW,
    parameter logic [CW-1:0] DEF_PERIOD = CW'(999)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_period,
    input  logic [CW-1:0] cfg_compare,
    input  logic          cfg_mode,
    input  logic          commit_opp,
    output logic          commit,
    output logic [CW-1:0] period_act,
    output logic [CW-1:0] compare_act,
    output carrier_mode_t mode_act,
    output logic          update_done
);

    logic [CW-1:0] period_sh;
    logic [CW-1:0] compare_sh;
    carrier_mode_t mode_sh;
    logic          pend;

    assign cfg_ready = !pend;
    assign commit    = pend && commit_opp;

    always_ff @(posedge clk) begin
        if (rst) begin
            period_sh   <= '0;
            compare_sh  <= '0;
            mode_sh     <= CARRIER_SAW;
            pend        <= 1'b0;
            period_act  <= DEF_PERIOD;
            compare_act <= '0;
            mode_act    <= CARRIER_SAW;
            update_done <= 1'b0;
        end else begin
            update_done <= commit;
            if (commit) begin
                period_act  <= period_sh;
                compare_act <= compare_sh;
                mode_act    <= mode_sh;
                pend        <= 1'b0;
            end else if (cfg_valid && !pend) begin
                period_sh  <= cfg_period;
                compare_sh <= cfg_compare;
                mode_sh    <= carrier_mode_t'(cfg_mode);
                pend       <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_carrier_gen.sv
// Sawtooth/triangle PWM carrier with glitch-free shadowed period, compare and mode updates.
module pwm_carrier_gen
    import pwm_pkg::*;
#(
    parameter int unsigned   CW            = PWM_CW,
    parameter logic [CW-1:0] DEF_PERIOD    = CW'(999),
    parameter bit            DOUBLE_UPDATE = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_period,
    input  logic [CW-1:0] cfg_compare,
    input  logic          cfg_mode,
    output logic [CW-1:0] carrier,
    output logic [CW-1:0] compare,
    output _pwm_onoff     pwm_onoff,
    output logic          zero_evt,
    output logic          peak_evt,
    output logic          update_done
);

    logic [CW-1:0] carrier_q, carrier_d;
    logic [CW-1:0] period_act;
    dir_t          dir_q, dir_d, dir_next;
    _pwm_onoff     onoff_q;
    carrier_mode_t mode_act;
    logic          running;
    logic          peak_flip;
    logic          commit_opp;
    logic          commit;

    assign running = (onoff_q == PWM_ON);

    // Counting only advances once running; the first running cycle therefore shows carrier=0.
    always_comb begin
        carrier_d = '0;
        dir_d     = DirUp;
        peak_flip = 1'b0;
        if (enable && running) begin
            if (mode_act == CARRIER_SAW) begin
                carrier_d = (carrier_q >= period_act) ? '0 : carrier_q + 1'b1;
            end else if (dir_q == DirUp) begin
                if (carrier_q >= period_act) begin
                    dir_d     = DirDown;
                    peak_flip = 1'b1;
                    carrier_d = (period_act == '0) ? '0 : period_act - 1'b1;
                end else begin
                    carrier_d = carrier_q + 1'b1;
                end
            end else begin
                if (carrier_q <= CW'(1)) begin
                    carrier_d = '0;
                end else begin
                    dir_d     = DirDown;
                    carrier_d = carrier_q - 1'b1;
                end
            end
        end
    end

    assign commit_opp = (carrier_d == '0) || (DOUBLE_UPDATE && peak_flip);

    // A zero-point commit may switch mode, so the new mode always starts counting up.
    assign dir_next = (commit && carrier_d == '0) ? DirUp : dir_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            carrier_q <= '0;
            dir_q     <= DirUp;
            onoff_q   <= PWM_OFF;
        end else begin
            carrier_q <= carrier_d;
            dir_q     <= dir_next;
            onoff_q   <= enable ? PWM_ON : PWM_OFF;
        end
    end

    pwm_shadow_reg #(
        .CW         (CW),
        .DEF_PERIOD (DEF_PERIOD)
    ) u_shadow (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_compare (cfg_compare),
        .cfg_mode    (cfg_mode),
        .commit_opp  (commit_opp),
        .commit      (commit),
        .period_act  (period_act),
        .compare_act (compare),
        .mode_act    (mode_act),
        .update_done (update_done)
    );

    assign carrier   = carrier_q;
    assign pwm_onoff = onoff_q;
    assign zero_evt  = running && (carrier_q == '0);
    assign peak_evt  = running && (carrier_q == period_act);

endmodule

// File: tb/tb_pwm_carrier_gen.sv
// Directed bench for pwm_carrier_gen: sawtooth, triangle, shadow handshake, enable and reset.
module tb_pwm_carrier_gen;
    import pwm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_period;
    logic [15:0] cfg_compare;
    logic        cfg_mode;
    logic [15:0] carrier;
    logic [15:0] compare;
    _pwm_onoff   pwm_onoff;
    logic        zero_evt;
    logic        peak_evt;
    logic        update_done;

    int checks   = 0;
    int failures = 0;

    pwm_carrier_gen dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_compare (cfg_compare),
        .cfg_mode    (cfg_mode),
        .carrier     (carrier),
        .compare     (compare),
        .pwm_onoff   (pwm_onoff),
        .zero_evt    (zero_evt),
        .peak_evt    (peak_evt),
        .update_done (update_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
        cfg_period = '0; cfg_compare = '0; cfg_mode = 1'b0;
        step();
        step();
        checks++;
        if (carrier !== 16'd0 || compare !== 16'd0 || pwm_onoff !== PWM_OFF || cfg_ready !== 1'b1)
            begin failures++;
            $display("FAIL reset_state: carrier=%0d compare=%0d onoff=%0d ready=%0b want 0 0 0 1",
                     carrier, compare, pwm_onoff, cfg_ready); end
        checks++;
        if (zero_evt !== 1'b0 || peak_evt !== 1'b0 || update_done !== 1'b0) begin failures++;
            $display("FAIL reset_events: zero=%0b peak=%0b upd=%0b want 0 0 0",
                     zero_evt, peak_evt, update_done); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_sawtooth();
        cfg_valid = 1'b1; cfg_period = 16'd4; cfg_compare = 16'd0; cfg_mode = 1'b0;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin failures++;
            $display("FAIL saw_capture_ready: got %0b want 0", cfg_ready); end
        step();
        checks++;
        if (update_done !== 1'b1 || cfg_ready !== 1'b1) begin failures++;
            $display("FAIL saw_idle_commit: upd=%0b ready=%0b want 1 1", update_done, cfg_ready); end
        enable = 1'b1;
        step();
        checks++;
        if (pwm_onoff !== PWM_ON) begin failures++;
            $display("FAIL saw_onoff: got %0d want %0d", pwm_onoff, PWM_ON); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (carrier !== 16'(i % 5) || zero_evt !== (i % 5 == 0) || peak_evt !== (i % 5 == 4))
                begin failures++;
                $display("FAIL saw_seq[%0d]: carrier=%0d zero=%0b peak=%0b want %0d %0b %0b", i,
                         carrier, zero_evt, peak_evt, i % 5, i % 5 == 0, i % 5 == 4); end
            step();
        end
    endtask

    task automatic test_compare_write();
        step();
        step();
        checks++;
        if (carrier !== 16'd2) begin failures++;
            $display("FAIL cmp_start: carrier=%0d want 2", carrier); end
        cfg_valid = 1'b1; cfg_period = 16'd4; cfg_compare = 16'd100; cfg_mode = 1'b0;
        step();
        checks++;
        if (cfg_ready !== 1'b0 || compare !== 16'd0) begin failures++;
            $display("FAIL cmp_pending: ready=%0b compare=%0d want 0 0", cfg_ready, compare); end
        cfg_compare = 16'd55;
        step();
        checks++;
        if (cfg_ready !== 1'b0 || compare !== 16'd0 || carrier !== 16'd4) begin failures++;
            $display("FAIL cmp_hold: ready=%0b compare=%0d carrier=%0d want 0 0 4",
                     cfg_ready, compare, carrier); end
        cfg_valid = 1'b0;
        step();
        checks++;
        if (carrier !== 16'd0 || compare !== 16'd100 || update_done !== 1'b1 || cfg_ready !== 1'b1)
            begin failures++;
            $display("FAIL cmp_commit: carrier=%0d compare=%0d upd=%0b ready=%0b want 0 100 1 1",
                     carrier, compare, update_done, cfg_ready); end
        step();
        checks++;
        if (update_done !== 1'b0 || compare !== 16'd100) begin failures++;
            $display("FAIL cmp_after: upd=%0b compare=%0d want 0 100", update_done, compare); end
    endtask

    task automatic test_period_change();
        cfg_valid = 1'b1; cfg_period = 16'd10; cfg_compare = 16'd100; cfg_mode = 1'b0;
        step();
        cfg_valid = 1'b0;
        step(); step(); step();
        checks++;
        if (carrier !== 16'd0 || update_done !== 1'b1) begin failures++;
            $display("FAIL p10_commit: carrier=%0d upd=%0b want 0 1", carrier, update_done); end
        cfg_valid = 1'b1; cfg_period = 16'd3;
        step();
        cfg_valid = 1'b0;
        repeat (9) step();
        checks++;
        if (carrier !== 16'd10 || peak_evt !== 1'b1) begin failures++;
            $display("FAIL p10_peak: carrier=%0d peak=%0b want 10 1", carrier, peak_evt); end
        step();
        checks++;
        if (carrier !== 16'd0 || update_done !== 1'b1) begin failures++;
            $display("FAIL p3_commit: carrier=%0d upd=%0b want 0 1", carrier, update_done); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (carrier !== 16'(i % 4) || peak_evt !== (i % 4 == 3)) begin failures++;
                $display("FAIL p3_seq[%0d]: carrier=%0d peak=%0b want %0d %0b", i, carrier,
                         peak_evt, i % 4, i % 4 == 3); end
            step();
        end
        cfg_valid = 1'b1; cfg_period = 16'd0;
        step();
        cfg_valid = 1'b0;
        step(); step();
        checks++;
        if (update_done !== 1'b1) begin failures++;
            $display("FAIL p0_commit: upd=%0b want 1", update_done); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (carrier !== 16'd0 || zero_evt !== 1'b1 || peak_evt !== 1'b1) begin failures++;
                $display("FAIL p0_stuck[%0d]: carrier=%0d zero=%0b peak=%0b want 0 1 1", i,
                         carrier, zero_evt, peak_evt); end
            step();
        end
    endtask

    task automatic test_triangle();
        logic [15:0] tri_seq [8] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd2, 16'd1, 16'd0, 16'd1};
        cfg_valid = 1'b1; cfg_period = 16'd3; cfg_compare = 16'd100; cfg_mode = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        checks++;
        if (update_done !== 1'b1 || carrier !== 16'd0) begin failures++;
            $display("FAIL tri_commit: upd=%0b carrier=%0d want 1 0", update_done, carrier); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (carrier !== tri_seq[i] || zero_evt !== (i == 0 || i == 6) || peak_evt !== (i == 3))
                begin failures++;
                $display("FAIL tri_seq[%0d]: carrier=%0d zero=%0b peak=%0b want %0d %0b %0b", i,
                         carrier, zero_evt, peak_evt, tri_seq[i], i == 0 || i == 6, i == 3); end
            step();
        end
    endtask

    task automatic test_enable_drop();
        cfg_valid = 1'b1; cfg_period = 16'd6; cfg_compare = 16'd100; cfg_mode = 1'b1;
        step();
        cfg_valid = 1'b0;
        step(); step(); step();
        checks++;
        if (update_done !== 1'b1 || carrier !== 16'd0) begin failures++;
            $display("FAIL p6_commit: upd=%0b carrier=%0d want 1 0", update_done, carrier); end
        repeat (7) step();
        checks++;
        if (carrier !== 16'd5) begin failures++;
            $display("FAIL en_down5: carrier=%0d want 5", carrier); end
        enable = 1'b0;
        step();
        checks++;
        if (carrier !== 16'd0 || pwm_onoff !== PWM_OFF || zero_evt !== 1'b0 || compare !== 16'd100)
            begin failures++;
            $display("FAIL en_off: carrier=%0d onoff=%0d zero=%0b compare=%0d want 0 0 0 100",
                     carrier, pwm_onoff, zero_evt, compare); end
        step();
        enable = 1'b1;
        step();
        checks++;
        if (carrier !== 16'd0 || pwm_onoff !== PWM_ON || zero_evt !== 1'b1) begin failures++;
            $display("FAIL en_on: carrier=%0d onoff=%0d zero=%0b want 0 1 1",
                     carrier, pwm_onoff, zero_evt); end
        step();
        step();
        checks++;
        if (carrier !== 16'd2) begin failures++;
            $display("FAIL en_count_up: carrier=%0d want 2", carrier); end
    endtask

    task automatic test_reset_pending();
        cfg_valid = 1'b1; cfg_period = 16'd20; cfg_compare = 16'd7; cfg_mode = 1'b0;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin failures++;
            $display("FAIL rstp_pending: ready=%0b want 0", cfg_ready); end
        rst = 1'b1;
        step();
        checks++;
        if (carrier !== 16'd0 || compare !== 16'd0 || cfg_ready !== 1'b1 || pwm_onoff !== PWM_OFF ||
            update_done !== 1'b0) begin failures++;
            $display("FAIL rstp_state: carrier=%0d compare=%0d ready=%0b onoff=%0d upd=%0b want 0 0 1 0 0",
                     carrier, compare, cfg_ready, pwm_onoff, update_done); end
        rst = 1'b0;
        step();
        checks++;
        if (carrier !== 16'd0 || pwm_onoff !== PWM_ON || update_done !== 1'b0 || compare !== 16'd0)
            begin failures++;
            $display("FAIL rstp_restart: carrier=%0d onoff=%0d upd=%0b compare=%0d want 0 1 0 0",
                     carrier, pwm_onoff, update_done, compare); end
        repeat (20) step();
        checks++;
        if (carrier !== 16'd20 || peak_evt !== 1'b0) begin failures++;
            $display("FAIL rstp_lost_write: carrier=%0d peak=%0b want 20 0", carrier, peak_evt); end
        repeat (979) step();
        checks++;
        if (carrier !== 16'd999 || peak_evt !== 1'b1) begin failures++;
            $display("FAIL rstp_def_peak: carrier=%0d peak=%0b want 999 1", carrier, peak_evt); end
        step();
        checks++;
        if (carrier !== 16'd0 || zero_evt !== 1'b1) begin failures++;
            $display("FAIL rstp_def_wrap: carrier=%0d zero=%0b want 0 1", carrier, zero_evt); end
    endtask

    initial begin
        test_reset();
        test_sawtooth();
        test_compare_write();
        test_period_change();
        test_triangle();
        test_enable_drop();
        test_reset_pending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_carrier_gen.md
Name: pwm_carrier_gen

Overview:
- Generates the 16-bit PWM carrier (sawtooth or triangle) plus the matching compare value and on/off enum.
- These outputs feed the PWM comparator stage downstream.
- Period, compare and mode are written into shadow registers through a valid/ready handshake.
- Shadow values commit to the active registers only at carrier update events, so the downstream comparator never sees a mid-period glitch.

Parameters:
- CW, 16: carrier/compare/period width.
- DEF_PERIOD, 16'd999: active period after reset.
- DOUBLE_UPDATE, 0: if 1, triangle mode also commits the shadow at the peak.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run request.
- cfg_valid  in  1  shadow write request.
- cfg_ready  out  1  shadow free; high when no commit is pending.
- cfg_period  in  CW  new period (peak value).
- cfg_compare  in  CW  new compare value.
- cfg_mode  in  1  0 = sawtooth, 1 = triangle.
- carrier  out  CW  carrier value, to the comparator.
- compare  out  CW  active compare value, to the comparator.
- pwm_onoff  out  _pwm_onoff  PWM_ON when running, else PWM_OFF.
- zero_evt  out  1  pulse, high for one cycle while carrier==0 (running only).
- peak_evt  out  1  pulse, high for one cycle while carrier==period_act (running only).
- update_done  out  1  pulse, high for one cycle after a shadow commit.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - carrier=0, dir=up.
  - period_act=DEF_PERIOD, compare=0, mode_act=sawtooth.
  - pend=0, cfg_ready=1.
  - pwm_onoff=PWM_OFF.
  - zero_evt=peak_evt=update_done=0.
- A reset mid-period abandons the period and discards any pending shadow.
- Handshake:
  - cfg_ready = !pend.
  - On cfg_valid && cfg_ready, capture cfg_period/compare/mode into the shadow and set pend=1.
  - cfg_valid while not ready is ignored; no capture. The writer holds the request.
- Commit:
  - Occurs on any clock edge where the next carrier value is 0 and pend=1.
  - With DOUBLE_UPDATE=1 in triangle mode, it also occurs on the edge where dir flips to down.
  - On commit: active <= shadow, pend <= 0, update_done=1 on the following cycle, cfg_ready rises the same cycle.
  - A new capture cannot coincide with a commit, because cfg_ready was low.
- Sawtooth counting:
  - If carrier >= period_act, carrier <= 0; otherwise carrier <= carrier+1.
  - Sequence length is period_act+1 cycles.
  - Using >= recovers cleanly if the period shrinks.
- Triangle counting: a two-state direction FSM, UP/DOWN.
  - UP: if carrier >= period_act, go to DOWN and load carrier <= period_act-1 (0 if period_act==0); otherwise increment.
  - DOWN: if carrier <= 1, go to UP with carrier <= 0; otherwise decrement.
  - Full cycle is 2*period_act cycles, with 0 and the peak each held one cycle.
- period_act==0 in either mode: carrier stays at 0, zero_evt and peak_evt are both high every cycle, and every edge is a commit opportunity.
- Mode change: the new mode takes effect only at commit, with carrier=0 and dir=UP.
- enable low:
  - carrier forced to 0, dir=UP, pwm_onoff=PWM_OFF, events low.
  - Pending shadow commits immediately.
  - Active compare is retained.
- enable rise: the first running cycle shows carrier=0.
- Alignment: pwm_onoff is registered from enable with the same one-cycle latency as carrier, so it stays aligned with carrier.
- Width rules: all arithmetic is unsigned CW-bit. Wrap past 2^CW-1 is impossible because of the >= compare.

Decomposition:
- Shared package pwm_pkg holds:
  - typedef enum _pwm_onoff {PWM_OFF, PWM_ON};
  - typedef enum {CARRIER_SAW, CARRIER_TRI} carrier_mode_t;
  - CW default.
- One natural sub-module: pwm_shadow_reg, holding the shadow/pending/commit logic.
- The counter/FSM stays in the top level.

Test Plan:
- Sawtooth, period=4, enable=1 from reset: carrier 0,1,2,3,4,0,…; zero_evt every 5 cycles; peak_evt on carrier=4.
- Triangle, period=3: carrier 0,1,2,3,2,1,0,1; zero and peak events spaced 3 cycles apart; 6-cycle period.
- Write compare=100 at carrier=2 (sawtooth, period=4):
  - cfg_ready drops.
  - compare stays 0 until carrier returns to 0, then shows 100.
  - update_done pulses once and cfg_ready returns to 1.
  - A second cfg_valid issued while pending is not captured.
- Period shrink 10→3 committed at wrap: next sequence 0..3. Period=0: carrier stuck at 0 with both events high.
- enable drop at triangle carrier=5 going DOWN: next cycle carrier=0 and pwm_onoff=PWM_OFF. On re-enable, counting starts 0,1 going UP and pwm_onoff=PWM_ON aligned with carrier=0.
- rst mid-period with a shadow pending: next cycle all reset values hold, period_act=DEF_PERIOD, cfg_ready=1, and the pending write is lost.
